// File: rtl/layer1_fm_pkg.sv
// Shared state encoding, defaults and sizing helper for the layer-1 feature-map scheduler.
package layer1_fm_pkg;

  localparam int unsigned DEF_N_CH    = 4;
  localparam int unsigned DEF_TIMEOUT = 65535;
  localparam int unsigned WD_W        = 20;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_WAIT_VS = 3'd1,
    ST_WR         = 3'd2,
    ST_WR_ACK     = 3'd3,
    ST_RD_WAIT    = 3'd4,
    ST_RD_START   = 3'd5,
    ST_RD_RUN     = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/layer1_fm_watchdog.sv
// Acknowledge-wait watchdog: counts cycles while enabled and flags TIMEOUT-1.
module layer1_fm_watchdog
  import layer1_fm_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt;

  // Saturates at the limit so a stalled abort cannot wrap the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + WD_W'(1);
    end
  end

  assign expired_c = (cnt == LIMIT);

endmodule

// File: rtl/layer1_fm_scheduler.sv
// Steers conv frames into the feature-map buffers one channel at a time, then
// replays each buffer to the layer-2 front end.
module layer1_fm_scheduler
  import layer1_fm_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned CH_W    = ch_width(N_CH),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            conv_vsync,
  output logic [N_CH-1:0] fm_wea,
  input  logic [N_CH-1:0] save_fm_acmp,
  input  logic            dn_ready,
  output logic [N_CH-1:0] start_output,
  input  logic [N_CH-1:0] end_output,
  output logic [CH_W-1:0] ch_sel,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t          state;
  state_t          state_n;
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] ch_n;
  logic            err_n;
  logic [N_CH-1:0] fm_wea_n;
  logic [N_CH-1:0] start_output_n;
  logic            busy_n;
  logic            done_n;

  logic            vs_q;
  logic            vs_prev;
  logic            vs_rise;
  logic            vs_fall;
  logic [N_CH-1:0] acmp_q;
  logic [N_CH-1:0] acmp_rise;
  logic [N_CH-1:0] ch_oh;
  logic            ack_hit;
  logic            end_hit;
  logic            in_wait;
  logic            wd_expired;

  // conv_vsync passes a sample register before edge detection; acmp is detected directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q    <= 1'b0;
      vs_prev <= 1'b0;
      acmp_q  <= '0;
    end else begin
      vs_q    <= conv_vsync;
      vs_prev <= vs_q;
      acmp_q  <= save_fm_acmp;
    end
  end

  assign vs_rise   = vs_q & ~vs_prev;
  assign vs_fall   = ~vs_q & vs_prev;
  assign acmp_rise = save_fm_acmp & ~acmp_q;
  assign ch_oh     = N_CH'(1) << ch;
  assign ack_hit   = |(acmp_rise & ch_oh);
  assign end_hit   = |(end_output & ch_oh);
  assign in_wait   = (state == ST_WR_ACK) || (state == ST_RD_RUN);

  layer1_fm_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_wait),
    .en       (in_wait),
    .expired_c(wd_expired)
  );

  // Next state, channel and error; outputs are decoded from the next state and registered.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    err_n   = err;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_WR_WAIT_VS;
          ch_n    = '0;
          err_n   = 1'b0;
        end
      end
      ST_WR_WAIT_VS: begin
        if (vs_rise) state_n = ST_WR;
      end
      ST_WR: begin
        if (vs_fall) state_n = ST_WR_ACK;
      end
      ST_WR_ACK: begin
        if (ack_hit) begin
          if (ch == LAST_CH) begin
            ch_n    = '0;
            state_n = ST_RD_WAIT;
          end else begin
            ch_n    = ch + CH_W'(1);
            state_n = ST_WR_WAIT_VS;
          end
        end else if (wd_expired) begin
          err_n   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_RD_WAIT: begin
        if (dn_ready) state_n = ST_RD_START;
      end
      ST_RD_START: begin
        state_n = ST_RD_RUN;
      end
      ST_RD_RUN: begin
        if (end_hit) begin
          if (ch == LAST_CH) begin
            state_n = ST_DONE;
          end else begin
            ch_n    = ch + CH_W'(1);
            state_n = ST_RD_WAIT;
          end
        end else if (wd_expired) begin
          err_n   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        ch_n    = '0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    fm_wea_n       = (state_n == ST_WR)       ? (N_CH'(1) << ch_n) : '0;
    start_output_n = (state_n == ST_RD_START) ? (N_CH'(1) << ch_n) : '0;
    busy_n         = (state_n != ST_IDLE);
    done_n         = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ch           <= '0;
      err          <= 1'b0;
      fm_wea       <= '0;
      start_output <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      ch           <= ch_n;
      err          <= err_n;
      fm_wea       <= fm_wea_n;
      start_output <= start_output_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

  assign ch_sel = ch;

endmodule

// File: tb/tb_layer1_fm_scheduler.sv
// Bench for layer1_fm_scheduler: a cycle table for the first frame, then
// scoreboarded full passes covering readout hold-off, timeout abort and reset.
module tb_layer1_fm_scheduler;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            conv_vsync;
  logic            dn_ready;
  logic [N_CH-1:0] save_fm_acmp;
  logic [N_CH-1:0] end_output;
  logic [N_CH-1:0] fm_wea;
  logic [N_CH-1:0] start_output;
  logic [CH_W-1:0] ch_sel;
  logic            busy;
  logic            done;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N_CH-1:0] exp_wea_q[$];
  logic [N_CH-1:0] exp_so_q[$];

  typedef struct packed {
    logic            start;
    logic            vs;
    logic [N_CH-1:0] ack;
    logic [N_CH-1:0] eo;
    logic [N_CH-1:0] wea;
    logic [N_CH-1:0] so;
    logic [CH_W-1:0] sel;
    logic            busy;
    logic            done;
    logic            err;
  } vec_t;

  vec_t vecs[12];

  layer1_fm_scheduler #(
    .N_CH   (N_CH),
    .CH_W   (CH_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .conv_vsync  (conv_vsync),
    .fm_wea      (fm_wea),
    .save_fm_acmp(save_fm_acmp),
    .dn_ready    (dn_ready),
    .start_output(start_output),
    .end_output  (end_output),
    .ch_sel      (ch_sel),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] oh(input int c);
    return N_CH'(1) << c;
  endfunction

  // Pops expected one-hots on each new write window and on every readout pulse.
  task automatic monitor();
    logic [N_CH-1:0] wea_prev;
    logic [N_CH-1:0] e;
    logic            d_now;
    wea_prev = '0;
    forever begin
      @(posedge clk);
      d_now = dn_ready;
      #1;
      if (fm_wea != '0 && wea_prev == '0) begin
        if (exp_wea_q.size() == 0) check("wea_unexpected", 32'(fm_wea), 32'd0);
        else begin
          e = exp_wea_q.pop_front();
          check("wea_order", 32'(fm_wea), 32'(e));
        end
      end
      wea_prev = fm_wea;
      if (start_output != '0) begin
        check("so_needs_dn_ready", 32'(d_now), 32'd1);
        if (exp_so_q.size() == 0) check("so_unexpected", 32'(start_output), 32'd0);
        else begin
          e = exp_so_q.pop_front();
          check("so_order", 32'(start_output), 32'(e));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start        = 1'b0;
    conv_vsync   = 1'b0;
    save_fm_acmp = '0;
    end_output   = '0;
    dn_ready     = 1'b0;
    repeat (3) @(negedge clk);
    exp_wea_q.delete();
    exp_so_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One layer pass; bad_ch aborts via a wrong-channel ack, rst_ch resets mid-write.
  task automatic run_pass(input int dn_hold, input int bad_ch, input int rst_ch, input bit poke);
    int              last_wr;
    int              k;
    logic [N_CH-1:0] m;
    last_wr = (bad_ch >= 0) ? bad_ch : (rst_ch >= 0) ? rst_ch : int'(N_CH) - 1;
    for (int c = 0; c <= last_wr; c++) exp_wea_q.push_back(oh(c));
    if (bad_ch < 0 && rst_ch < 0)
      for (int c = 0; c < int'(N_CH); c++) exp_so_q.push_back(oh(c));
    dn_ready = (dn_hold == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_err_clear", 32'(err), 32'd0);
    check("start_ch_sel", 32'(ch_sel), 32'd0);

    for (int c = 0; c <= last_wr; c++) begin
      m = oh(c);
      repeat (3) @(negedge clk);
      conv_vsync = 1'b1;
      @(negedge clk);
      check("wea_rise_early", 32'(fm_wea), 32'd0);
      @(negedge clk);
      check("wea_rise_lat", 32'(fm_wea), 32'(m));
      check("wr_ch_sel", 32'(ch_sel), 32'(c));
      if (c == rst_ch) begin
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_wea", 32'(fm_wea), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ch_sel", 32'(ch_sel), 32'd0);
        @(negedge clk);
        conv_vsync = 1'b0;
        exp_wea_q.delete();
        exp_so_q.delete();
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      repeat (98) @(negedge clk);
      conv_vsync = 1'b0;
      @(negedge clk);
      check("wea_fall_early", 32'(fm_wea), 32'(m));
      @(negedge clk);
      check("wea_fall_lat", 32'(fm_wea), 32'd0);
      repeat (8) @(negedge clk);
      save_fm_acmp = (c == bad_ch) ? (m << 1) : m;
      repeat (2) @(negedge clk);
      save_fm_acmp = '0;
      if (c == bad_ch) begin
        k = 12;
        while (done !== 1'b1 && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("abort_latency", 32'(k), 32'd66);
        check("abort_err", 32'(err), 32'd1);
        check("abort_wea", 32'(fm_wea), 32'd0);
        @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_ch_sel", 32'(ch_sel), 32'd0);
        check("abort_done_width", 32'(done), 32'd0);
        return;
      end
      check("ack_ch_sel", 32'(ch_sel), (c == int'(N_CH) - 1) ? 32'd0 : 32'(c + 1));
    end

    for (int c = 0; c < int'(N_CH); c++) begin
      m = oh(c);
      if (dn_hold > 0) begin
        repeat (dn_hold) @(negedge clk);
        check("so_held_off", 32'(start_output), 32'd0);
        dn_ready = 1'b1;
        @(negedge clk);
        check("so_rdy_lat", 32'(start_output), 32'(m));
        dn_ready = 1'b0;
      end else begin
        k = 0;
        while (start_output == '0 && k < 50) begin
          @(negedge clk);
          k++;
        end
        check("so_lat", 32'(k), (c == 0) ? 32'd0 : 32'd1);
        check("so_bit", 32'(start_output), 32'(m));
      end
      for (int j = 1; j < 50; j++) begin
        @(negedge clk);
        if (j == 1) check("so_width", 32'(start_output), 32'd0);
        if (poke && c == 1 && j == 20) start = 1'b1;
        if (poke && c == 1 && j == 21) begin
          start = 1'b0;
          check("poke_ch_sel", 32'(ch_sel), 32'd1);
          check("poke_busy", 32'(busy), 32'd1);
          check("poke_so", 32'(start_output), 32'd0);
          check("poke_done", 32'(done), 32'd0);
        end
      end
      end_output = m;
      @(negedge clk);
      end_output = '0;
      if (c == int'(N_CH) - 1) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_err", 32'(err), 32'd0);
        check("done_ch_sel", 32'(ch_sel), 32'(N_CH - 1));
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ch_sel", 32'(ch_sel), 32'd0);
      end
    end
    check("wea_q_empty", 32'(exp_wea_q.size()), 32'd0);
    check("so_q_empty", 32'(exp_so_q.size()), 32'd0);
  endtask

  initial begin
    // start, vs, ack, eo | wea, so, sel, busy, done, err
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};

    rst          = 1'b1;
    start        = 1'b0;
    conv_vsync   = 1'b0;
    save_fm_acmp = '0;
    dn_ready     = 1'b0;
    end_output   = '0;
    fork
      monitor();
    join_none

    do_reset();
    check("rst_fm_wea", 32'(fm_wea), 32'd0);
    check("rst_start_output", 32'(start_output), 32'd0);
    check("rst_ch_sel", 32'(ch_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    exp_wea_q.push_back(oh(0));
    foreach (vecs[i]) begin
      start        = vecs[i].start;
      conv_vsync   = vecs[i].vs;
      save_fm_acmp = vecs[i].ack;
      end_output   = vecs[i].eo;
      @(negedge clk);
      check($sformatf("vec%0d_wea", i), 32'(fm_wea), 32'(vecs[i].wea));
      check($sformatf("vec%0d_so", i), 32'(start_output), 32'(vecs[i].so));
      check($sformatf("vec%0d_sel", i), 32'(ch_sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
    end
    check("vec_wea_q_empty", 32'(exp_wea_q.size()), 32'd0);
    do_reset();

    run_pass(0, -1, -1, 1'b1);
    run_pass(0, 1, -1, 1'b0);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("err_sticky_idle", 32'(busy), 32'd0);
    run_pass(200, -1, -1, 1'b0);
    run_pass(0, -1, 2, 1'b0);
    run_pass(0, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
